// File: rtl/gsram_fifo_pkg.sv
// Shared types and constants for the SRAM-backed streaming FIFO controller.
package gsram_fifo_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int OB_DEPTH = 2;
    localparam int OB_CW    = $clog2(OB_DEPTH + 1);

    // Width of a ptr_t for a given address width: address bits plus the wrap bit.
    function automatic int ptr_bits(input int abits);
        return abits + 1;
    endfunction

endpackage

// File: rtl/gsram_fifo_outbuf.sv
// Two-entry registered output buffer refilled from the SRAM read port.
module gsram_fifo_outbuf
    import gsram_fifo_pkg::*;
#(
    parameter int DBITS = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [DBITS-1:0] push_data,
    input  logic             pop,
    output logic [DBITS-1:0] head,
    output logic [OB_CW-1:0] cnt
);

    logic [DBITS-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [OB_CW-1:0] cnt_q, cnt_d;

    // e0 is always the head, so it only changes on a pop or a push into an empty buffer.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == '0) e0_d = push_data;
                else             e1_d = push_data;
                cnt_d = cnt_q + OB_CW'(1);
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - OB_CW'(1);
            end
            2'b11: begin
                if (cnt_q == OB_CW'(1)) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head = e0_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/gsram_fifo_ctrl.sv
// Streaming FIFO controller over a dual-port SRAM (port 0 write, port 1 read).
// Define GSRAM_FIFO_CLEAR_EN to zero the whole SRAM in an INIT sweep after reset.
module gsram_fifo_ctrl
    import gsram_fifo_pkg::*;
#(
    parameter int ABITS = 13,
    parameter int DBITS = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DBITS-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DBITS-1:0] out_data,
    output logic [ABITS+1:0] level,
    output logic             busy,
    output logic [ABITS-1:0] sram_a0,
    output logic [DBITS-1:0] sram_d0,
    output logic             sram_we0,
    output logic             sram_ce0,
    output logic [DBITS-1:0] sram_wem0,
    output logic [ABITS-1:0] sram_a1,
    output logic             sram_ce1,
    output logic [DBITS-1:0] sram_d1,
    output logic             sram_we1,
    output logic [DBITS-1:0] sram_wem1,
    input  logic [DBITS-1:0] sram_q1
);

    localparam int PW = ptr_bits(ABITS);
    localparam int OW = OB_CW + 1;
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(1) << ABITS;

    state_e           state;
    logic             run, init_we, wr, rd, pop, infl_q, infl_d;
    logic [ABITS-1:0] init_a;
    ptr_t             wptr_q, wptr_d, rptr_q, rptr_d, mem_cnt;
    logic [OB_CW-1:0] ob_cnt;
    logic [OW-1:0]    occ;

`ifdef GSRAM_FIFO_CLEAR_EN
    state_e           state_q, state_d;
    logic [ABITS-1:0] init_q, init_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= INIT;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        if (state_q == INIT) begin
            init_d = init_q + ABITS'(1);
            if (&init_q) state_d = RUN;
        end
    end

    assign state   = state_q;
    assign init_a  = init_q;
    assign init_we = rstn && (state_q == INIT);
    assign busy    = (state_q == INIT);
`else
    assign state   = RUN;
    assign init_a  = '0;
    assign init_we = 1'b0;
    assign busy    = 1'b0;
`endif

    // Gating with rstn keeps every handshake and SRAM strobe low while reset is held.
    assign run     = rstn && (state == RUN);
    assign mem_cnt = wptr_q - rptr_q;
    assign pop     = out_valid && out_ready;
    assign occ     = OW'(ob_cnt) + OW'(infl_q) - OW'(pop);

    assign in_ready = run && (mem_cnt != DEPTH_P);
    assign wr       = in_valid && in_ready;
    assign rd       = run && (mem_cnt != '0) && (occ < OW'(OB_DEPTH));

    always_comb begin
        wptr_d = wr ? wptr_q + ptr_t'(1) : wptr_q;
        rptr_d = rd ? rptr_q + ptr_t'(1) : rptr_q;
        infl_d = rd;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            infl_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            infl_q <= infl_d;
        end
    end

    gsram_fifo_outbuf #(.DBITS(DBITS)) u_outbuf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (infl_q),
        .push_data (sram_q1),
        .pop       (pop),
        .head      (out_data),
        .cnt       (ob_cnt)
    );

    assign out_valid = (ob_cnt != '0);
    assign level     = (ABITS+2)'(mem_cnt) + (ABITS+2)'(infl_q) + (ABITS+2)'(ob_cnt);

    assign sram_ce0  = wr || init_we;
    assign sram_we0  = sram_ce0;
    assign sram_a0   = init_we ? init_a : wptr_q[ABITS-1:0];
    assign sram_d0   = wr ? in_data : '0;
    assign sram_wem0 = {DBITS{sram_we0}};

    assign sram_ce1  = rd;
    assign sram_a1   = rptr_q[ABITS-1:0];
    assign sram_d1   = '0;
    assign sram_we1  = 1'b0;
    assign sram_wem1 = '0;

endmodule
